// File: rtl/fpu_fp32_to_fp64.sv
// fpu_fp32_to_fp64: widen FP32 to FP64, normalising denormals one bit per cycle
module fpu_fp32_to_fp64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dst,
  output logic        flag_inv,
  output logic        busy
);
  typedef enum logic {IDLE, NORM} state_t;
  state_t      state;
  logic [22:0] m;
  logic [10:0] x;
  logic        sgn;
  logic        s;
  logic [7:0]  e;
  logic [22:0] f;
  logic [63:0] fast;
  logic        fast_inv;
  logic        is_den;
  logic        accept;
  assign s = src[31];
  assign e = src[30:23];
  assign f = src[22:0];
  assign busy = state == NORM;
  assign in_ready = state == IDLE && (!out_valid || out_ready) && !flush;
  assign accept = in_valid && in_ready;
  assign is_den = e == 8'd0 && f != 23'd0;
  always_comb begin
    fast = e == 8'd0 ? {s, 63'b0} :
           e == 8'hff ? (f == 23'd0 ? {s, 11'h7ff, 52'b0} : {s, 11'h7ff, 1'b1, f[21:0], 29'b0}) :
           {s, {3'b0, e} + 11'd896, f, 29'b0};
    fast_inv = e == 8'hff && f != 23'd0 && !f[22];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      m <= '0;
      x <= '0;
      sgn <= 1'b0;
      out_valid <= 1'b0;
      dst <= '0;
      flag_inv <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
      flag_inv <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept && is_den) begin
          state <= NORM;
          m <= f;
          x <= 11'd897;
          sgn <= s;
        end else if (accept) begin
          dst <= fast;
          flag_inv <= fast_inv;
          out_valid <= 1'b1;
        end
      end else begin
        m <= m << 1;
        x <= x - 11'd1;
        if (m[22]) begin
          dst <= {sgn, x - 11'd1, m[21:0], 30'b0};
          flag_inv <= 1'b0;
          out_valid <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule
